conv_mac_engine: RTL and testbench

CONV_MAC_ENGINE -- requirements
Module: conv_mac_engine

---
 rtl/conv_pkg.sv | 17 +
 rtl/mac8x8_acc.sv | 23 ++
 rtl/conv_mac_engine.sv | 104 ++++++++++
 tb/tb_conv_mac_engine.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, loop bounds, FSM states and image index helper for the 2x2 valid-convolution MAC engine.
package conv_pkg;
  localparam int ACC_W  = 20;
  localparam int TAPS   = 9;
  localparam int PIXELS = 4;
  localparam int IMG_W  = 4;
  localparam int KER_W  = 3;
  localparam int OUT_W  = 2;
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  // image byte under tap k of output pixel p (both walked row-major)
  function automatic logic [3:0] img_index(input logic [1:0] p, input logic [3:0] k);
    int r, c;
    r = int'(p) / OUT_W + int'(k) / KER_W;
    c = int'(p) % OUT_W + int'(k) % KER_W;
    return 4'(r * IMG_W + c);
  endfunction
endpackage

// File: rtl/mac8x8_acc.sv
// mac8x8_acc: 8x8 unsigned multiplier feeding an ACC_W accumulator.
// Ports: clk, rst (async active-low), clr (zero acc, wins over en), en (acc += a*b),
// a/b (8-bit operands), sum (acc + a*b, combinational, used to capture the final tap).
module mac8x8_acc #(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic [ACC_W-1:0] sum
);
  logic [ACC_W-1:0] acc;
  logic [15:0] prod;
  assign prod = a * b;
  assign sum = acc + ACC_W'(prod);
  always_ff @(posedge clk or negedge rst)
    if (!rst) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= sum;
endmodule

// File: rtl/conv_mac_engine.sv
// conv_mac_engine: 3x3 kernel over a 4x4 image giving a 2x2 valid convolution, one MAC per cycle (36 MAC cycles + 1 DONE cycle).
// Ports: clk, rst (async active-low), start (begin a pass from IDLE), input_data0..15 (image, row-major),
// filter_data0..8 (kernel, row-major), busy (MAC or DONE), done (one-cycle pulse), result0..3 (2x2 output, row-major).
// Build option: define CONV_SAT_EN to clamp each written result to 255.
module conv_mac_engine #(
  parameter int ACC_W = conv_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       input_data0,
  input  logic [7:0]       input_data1,
  input  logic [7:0]       input_data2,
  input  logic [7:0]       input_data3,
  input  logic [7:0]       input_data4,
  input  logic [7:0]       input_data5,
  input  logic [7:0]       input_data6,
  input  logic [7:0]       input_data7,
  input  logic [7:0]       input_data8,
  input  logic [7:0]       input_data9,
  input  logic [7:0]       input_data10,
  input  logic [7:0]       input_data11,
  input  logic [7:0]       input_data12,
  input  logic [7:0]       input_data13,
  input  logic [7:0]       input_data14,
  input  logic [7:0]       input_data15,
  input  logic [7:0]       filter_data0,
  input  logic [7:0]       filter_data1,
  input  logic [7:0]       filter_data2,
  input  logic [7:0]       filter_data3,
  input  logic [7:0]       filter_data4,
  input  logic [7:0]       filter_data5,
  input  logic [7:0]       filter_data6,
  input  logic [7:0]       filter_data7,
  input  logic [7:0]       filter_data8,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result0,
  output logic [ACC_W-1:0] result1,
  output logic [ACC_W-1:0] result2,
  output logic [ACC_W-1:0] result3
);
  import conv_pkg::*;
  state_t state, next;
  logic [7:0] img_in [16];
  logic [7:0] flt_in [9];
  logic [7:0] img_s [16];
  logic [7:0] flt_s [9];
  logic [ACC_W-1:0] res [4];
  logic [ACC_W-1:0] sum, wr;
  logic [3:0] tap;
  logic [1:0] pix;
  logic take, last_tap, last;
  assign img_in = '{input_data0, input_data1, input_data2, input_data3,
                    input_data4, input_data5, input_data6, input_data7,
                    input_data8, input_data9, input_data10, input_data11,
                    input_data12, input_data13, input_data14, input_data15};
  assign flt_in = '{filter_data0, filter_data1, filter_data2, filter_data3, filter_data4,
                    filter_data5, filter_data6, filter_data7, filter_data8};
  assign {result0, result1, result2, result3} = {res[0], res[1], res[2], res[3]};
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  always_comb begin
    take = state == IDLE && start;
    last_tap = state == MAC && tap == 4'(TAPS - 1);
    last = last_tap && pix == 2'(PIXELS - 1);
    busy = state != IDLE;
    done = state == DONE;
    next = take ? MAC : last ? DONE : state == DONE ? IDLE : state;
  end
`ifdef CONV_SAT_EN
  assign wr = sum > ACC_W'(255) ? ACC_W'(255) : sum;
`else
  assign wr = sum;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      img_s <= '{default: '0};
      flt_s <= '{default: '0};
      res <= '{default: '0};
      tap <= '0;
      pix <= '0;
    end else if (take) begin
      img_s <= img_in;
      flt_s <= flt_in;
      tap <= '0;
      pix <= '0;
    end else if (state == MAC) begin
      tap <= last_tap ? '0 : tap + 4'd1;
      pix <= last_tap ? pix + 2'd1 : pix;
      if (last_tap) res[pix] <= wr;
    end
  // clearing on the final tap lets the next pixel start from zero without a bubble
  mac8x8_acc #(.ACC_W(ACC_W)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (take || last_tap),
    .en  (state == MAC),
    .a   (img_s[img_index(pix, tap)]),
    .b   (flt_s[tap]),
    .sum (sum)
  );
endmodule

// File: tb/tb_conv_mac_engine.sv
// tb_conv_mac_engine: table-driven and randomized checks of conv_mac_engine against a 2D convolution model.
module tb_conv_mac_engine;
  localparam int AW = 20;
  localparam logic [7:0] CB_IMG [16] = '{8'd137, 8'd139, 8'd1, 8'd162, 8'd36, 8'd206, 8'd231, 8'd205,
                                         8'd13, 8'd154, 8'd102, 8'd209, 8'd122, 8'd40, 8'd57, 8'd200};
  localparam logic [7:0] CB_FLT [9] = '{8'd165, 8'd213, 8'd198, 8'd124, 8'd79, 8'd77, 8'd111, 8'd172, 8'd162};
  typedef struct {
    string name;
    logic [7:0] im [16];
    logic [7:0] fl [9];
    logic use_model;
    logic [AW-1:0] ex [4];
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [7:0] img [16];
  logic [7:0] flt [9];
  logic busy, done;
  logic [AW-1:0] res [4];
  logic [AW-1:0] exp_r [4];
  vec_t tbl [9];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  conv_mac_engine dut (
    .clk(clk), .rst(rst), .start(start),
    .input_data0(img[0]), .input_data1(img[1]), .input_data2(img[2]), .input_data3(img[3]),
    .input_data4(img[4]), .input_data5(img[5]), .input_data6(img[6]), .input_data7(img[7]),
    .input_data8(img[8]), .input_data9(img[9]), .input_data10(img[10]), .input_data11(img[11]),
    .input_data12(img[12]), .input_data13(img[13]), .input_data14(img[14]), .input_data15(img[15]),
    .filter_data0(flt[0]), .filter_data1(flt[1]), .filter_data2(flt[2]), .filter_data3(flt[3]),
    .filter_data4(flt[4]), .filter_data5(flt[5]), .filter_data6(flt[6]), .filter_data7(flt[7]),
    .filter_data8(flt[8]),
    .busy(busy), .done(done),
    .result0(res[0]), .result1(res[1]), .result2(res[2]), .result3(res[3])
  );
  task automatic check(input string nm, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask
  function automatic longint clip(input longint s);
`ifdef CONV_SAT_EN
    return s > 255 ? 255 : s;
`else
    return s;
`endif
  endfunction
  // plain 2D valid convolution over the current img/flt
  task automatic model();
    for (int oy = 0; oy < 2; oy++)
      for (int ox = 0; ox < 2; ox++) begin
        longint s = 0;
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            s += longint'(img[(oy + ky) * 4 + ox + kx]) * longint'(flt[ky * 3 + kx]);
        exp_r[oy * 2 + ox] = AW'(clip(s));
      end
  endtask
  task automatic set_codebase();
    img = CB_IMG;
    flt = CB_FLT;
    exp_r[0] = AW'(clip(135390));
    exp_r[1] = AW'(clip(183298));
    exp_r[2] = AW'(clip(146844));
    exp_r[3] = AW'(clip(213674));
  endtask
  // returns at the first negedge after the edge that sampled start (cycle 1 of the pass)
  task automatic kick();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  task automatic wait_done(input string nm);
    int n = 1;
    check({nm, " busy"}, longint'(busy), 1);
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
    end
    check({nm, " latency"}, n, 37);
  endtask
  task automatic check_res(input string nm);
    for (int i = 0; i < 4; i++) check($sformatf("%s result%0d", nm, i), longint'(res[i]), longint'(exp_r[i]));
  endtask
  initial begin
    int n, cnt, first, second;
    tbl[0].name = "codebase"; tbl[0].im = CB_IMG; tbl[0].fl = CB_FLT; tbl[0].use_model = 1'b0;
    tbl[0].ex = '{AW'(clip(135390)), AW'(clip(183298)), AW'(clip(146844)), AW'(clip(213674))};
    tbl[1].name = "all255"; tbl[1].im = '{default: 8'd255}; tbl[1].fl = '{default: 8'd255}; tbl[1].use_model = 1'b0;
    tbl[1].ex = '{default: AW'(clip(585225))};
    tbl[2].name = "zeros"; tbl[2].im = '{default: 8'd0}; tbl[2].fl = '{default: 8'd255}; tbl[2].use_model = 1'b0;
    tbl[2].ex = '{default: '0};
    for (int v = 3; v < 9; v++) begin
      tbl[v].name = $sformatf("rand%0d", v);
      for (int i = 0; i < 16; i++) tbl[v].im[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 9; i++) tbl[v].fl[i] = (v == 8) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      tbl[v].use_model = 1'b1;
      tbl[v].ex = '{default: '0};
    end
    img = '{default: 8'd0};
    flt = '{default: 8'd0};
    #1;
    check("reset busy", longint'(busy), 0);
    check("reset done", longint'(done), 0);
    for (int i = 0; i < 4; i++) check($sformatf("reset result%0d", i), longint'(res[i]), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int v = 0; v < 9; v++) begin
      img = tbl[v].im;
      flt = tbl[v].fl;
      if (tbl[v].use_model) model();
      else exp_r = tbl[v].ex;
      kick();
      wait_done(tbl[v].name);
      check_res(tbl[v].name);
      @(negedge clk);
      check({tbl[v].name, " done drop"}, longint'(done), 0);
      check({tbl[v].name, " idle"}, longint'(busy), 0);
    end
    // results hold while inputs wander in IDLE
    img = '{default: 8'd7};
    repeat (5) @(negedge clk);
    check_res("hold");
    // start mid-pass is ignored
    set_codebase();
    kick();
    n = 1; cnt = 0; first = 0;
    while (n < 80) begin
      if (n == 10) start = 1'b1;
      if (n == 11) start = 1'b0;
      if (done) begin
        cnt++;
        if (first == 0) first = n;
      end
      @(negedge clk);
      n++;
    end
    check("midstart done count", cnt, 1);
    check("midstart latency", first, 37);
    check_res("midstart");
    // inputs zeroed one cycle after start do not disturb the pass
    set_codebase();
    kick();
    img = '{default: 8'd0};
    flt = '{default: 8'd0};
    wait_done("snapshot");
    check_res("snapshot");
    // reset at MAC cycle 20 aborts the pass
    set_codebase();
    kick();
    n = 1;
    while (n < 20) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b0;
    #1;
    check("abort busy", longint'(busy), 0);
    check("abort done", longint'(done), 0);
    for (int i = 0; i < 4; i++) check($sformatf("abort result%0d", i), longint'(res[i]), 0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) cnt++;
    end
    rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort no done", cnt, 0);
    kick();
    wait_done("after abort");
    check_res("after abort");
    // start held high re-triggers on the first IDLE cycle after DONE
    img = tbl[4].im;
    flt = tbl[4].fl;
    model();
    @(negedge clk) start = 1'b1;
    n = 0; first = 0; second = 0;
    while (n < 76) begin
      @(negedge clk);
      n++;
      if (done && first == 0) first = n;
      else if (done && second == 0) second = n;
      if (n == 38) check("held gap idle", longint'(busy), 0);
    end
    start = 1'b0;
    check("held first done", first, 37);
    check("held second done", second, 75);
    check_res("held");
    @(negedge clk);
    check("held stop", longint'(busy), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
